bcd_count_ctrl: RTL and testbench

Sequencing controller for the two-digit BCD display path (two `bcd7seg` decoders driving HEX1/HEX0). It holds a two-digit BCD value, steps it up or down at a prescaled tick rate, and runs a small run/hold state machine. Its `digit1`/`digit0` outputs drive the decoder inputs directly, replacing the raw switch nibbles. Loads are validated so the decoders never receive a non-BCD code from this block.

---
 rtl/bcd_count_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bcd_count_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: two-digit BCD up/down counter with a run/hold/idle
// sequencer and a prescaled step rate. The digit outputs feed the two
// seven-segment decoders directly, so only validated BCD codes ever reach them.

module bcd_count_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000  // clock cycles per count step, >= 2
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       run,
  input  logic       up,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       tick,
  output logic       wrap,
  output logic       load_err,
  output logic [1:0] state
);

  // Prescaler width: enough bits to hold TICK_DIV-1.
  localparam int unsigned PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_BAD  = 2'b11   // unreachable encoding, recovers to IDLE
  } state_t;

  state_t cur_state, nxt_state;

  logic [PS_W-1:0] presc, presc_nxt;
  logic [3:0]      d1_nxt, d0_nxt;
  logic            tick_nxt, wrap_nxt, err_nxt;

  // Step candidates computed from the current digits and direction.
  logic [3:0]      step_d1, step_d0;
  logic            step_wrap;

  logic            load_ok;
  logic            at_last;

  assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
  assign at_last = (presc == PS_LAST);
  assign state   = cur_state;

  // State register.
  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // rather than in the sensitivity list; it also outranks every other input.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic: run level drives RUN/HOLD, clear forces IDLE.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_IDLE: if (run)  nxt_state = ST_RUN;
      ST_RUN:  if (!run) nxt_state = ST_HOLD;
      ST_HOLD: if (run)  nxt_state = ST_RUN;
      default:           nxt_state = ST_IDLE;
    endcase
    if (clear) begin
      nxt_state = ST_IDLE;
    end
  end

  // BCD step: units carry/borrow into tens, 99<->00 flags a wrap.
  always_comb begin
    step_d1   = digit1;
    step_d0   = digit0;
    step_wrap = 1'b0;
    if (up) begin
      if (digit0 == 4'd9) begin
        step_d0 = 4'd0;
        if (digit1 == 4'd9) begin
          step_d1   = 4'd0;
          step_wrap = 1'b1;
        end else begin
          step_d1 = digit1 + 4'd1;
        end
      end else begin
        step_d0 = digit0 + 4'd1;
      end
    end else begin
      if (digit0 == 4'd0) begin
        step_d0 = 4'd9;
        if (digit1 == 4'd0) begin
          step_d1   = 4'd9;
          step_wrap = 1'b1;
        end else begin
          step_d1 = digit1 - 4'd1;
        end
      end else begin
        step_d0 = digit0 - 4'd1;
      end
    end
  end

  // Datapath next values in priority order: clear, load, then prescaled step.
  always_comb begin
    presc_nxt = presc;
    d1_nxt    = digit1;
    d0_nxt    = digit0;
    tick_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (clear) begin
      // A coincident load is dropped silently.
      presc_nxt = '0;
      d1_nxt    = 4'd0;
      d0_nxt    = 4'd0;
    end else if (load) begin
      // Load outranks any step due on this edge; a rejected load only flags.
      if (load_ok) begin
        presc_nxt = '0;
        d1_nxt    = load_val[7:4];
        d0_nxt    = load_val[3:0];
      end else begin
        err_nxt = 1'b1;
      end
    end else begin
      case (cur_state)
        ST_RUN: begin
          if (!at_last) begin
            // Keeps advancing on the edge that drops run, so a resume
            // finishes the remaining TICK_DIV-1-p cycles.
            presc_nxt = presc + PS_W'(1);
          end else if (run) begin
            presc_nxt = '0;
            d1_nxt    = step_d1;
            d0_nxt    = step_d0;
            tick_nxt  = 1'b1;
            wrap_nxt  = step_wrap;
          end
        end
        ST_HOLD: begin
          // Frozen, not cleared.
        end
        default: begin
          presc_nxt = '0;
        end
      endcase
    end
  end

  // Datapath registers: digits, prescaler and the one-cycle pulses.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      presc    <= '0;
      digit1   <= 4'd0;
      digit0   <= 4'd0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      presc    <= presc_nxt;
      digit1   <= d1_nxt;
      digit0   <= d0_nxt;
      tick     <= tick_nxt;
      wrap     <= wrap_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl with TICK_DIV=4: a decimal-value model checked
// against the DUT on every cycle, plus hand-computed literal expectations.

module tb_bcd_count_ctrl;

  localparam int TD = 4;

  logic       Clock = 1'b0;
  logic       Resetn, clear, load, run, up;
  logic [7:0] load_val;
  logic [3:0] digit1, digit0;
  logic       tick, wrap, load_err;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  bcd_count_ctrl #(.TICK_DIV(TD)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .run      (run),
    .up       (up),
    .digit1   (digit1),
    .digit0   (digit0),
    .tick     (tick),
    .wrap     (wrap),
    .load_err (load_err),
    .state    (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the count is a decimal value 0..99, state is 0 idle / 1 run / 2 hold,
  // m_cnt is the number of RUN cycles accumulated toward the next step.
  int m_val = 0, m_st = 0, m_cnt = 0;
  bit m_tick = 0, m_wrap = 0, m_err = 0;
  bit started = 0;

  always @(posedge Clock) begin : model
    int  v, s, c;
    bit  t, w, e;
    v = m_val; s = m_st; c = m_cnt; t = 0; w = 0; e = 0;
    if (!Resetn) begin
      v = 0; s = 0; c = 0;
    end else begin
      if (clear) begin
        v = 0; c = 0;
      end else if (load) begin
        if (load_val[7:4] < 10 && load_val[3:0] < 10) begin
          v = 10 * int'(load_val[7:4]) + int'(load_val[3:0]);
          c = 0;
        end else begin
          e = 1;
        end
      end else if (s == 1) begin
        if (c + 1 < TD) begin
          c = c + 1;
        end else if (run) begin
          c = 0;
          t = 1;
          if (up) begin
            w = (v == 99);
            v = (v + 1) % 100;
          end else begin
            w = (v == 0);
            v = (v + 99) % 100;
          end
        end
      end else if (s != 2) begin
        c = 0;
      end
      if (clear) s = 0;
      else if (s == 0 && run) s = 1;
      else if (s == 1 && !run) s = 2;
      else if (s == 2 && run) s = 1;
      else if (s == 3) s = 0;
    end
    m_val   <= v;
    m_st    <= s;
    m_cnt   <= c;
    m_tick  <= t;
    m_wrap  <= w;
    m_err   <= e;
    started <= 1'b1;
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge Clock) begin
    if (started) begin
      check("digit1",   digit1,   m_val / 10);
      check("digit0",   digit0,   m_val % 10);
      check("tick",     tick,     m_tick);
      check("wrap",     wrap,     m_wrap);
      check("load_err", load_err, m_err);
      check("state",    state,    m_st);
    end
  end

  // Pulse counters sampled shortly after each rising edge.
  int cnt_tick = 0, cnt_wrap = 0, cnt_err = 0;
  always begin
    @(posedge Clock);
    #2;
    if (tick === 1'b1)     cnt_tick++;
    if (wrap === 1'b1)     cnt_wrap++;
    if (load_err === 1'b1) cnt_err++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    @(negedge Clock);
    load = 1'b0;
  endtask

  task automatic expect_bcd(input string name, input logic [7:0] hex_exp, input int dec_exp);
    check(name, {digit1, digit0}, hex_exp);
    check({name, "_model"}, m_val, dec_exp);
  endtask

  initial begin
    int t0, w0, e0;
    Resetn = 1'b0; clear = 1'b0; load = 1'b1; load_val = 8'h12; run = 1'b1; up = 1'b1;

    // Reset held two cycles with run and load asserted.
    cyc(2);
    expect_bcd("rst_digits", 8'h00, 0);
    check("rst_state", state, 2'b00);
    check("rst_pulses", {tick, wrap, load_err}, 3'b000);
    Resetn = 1'b1; load = 1'b0;
    cyc(1);
    check("rst_release_run", state, 2'b01);

    // Count up through the 99->00 wrap.
    t0 = cnt_tick; w0 = cnt_wrap;
    do_load(8'h98);
    expect_bcd("up_load98", 8'h98, 98);
    cyc(3);
    check("up_no_early_tick", cnt_tick - t0, 0);
    cyc(1);
    expect_bcd("up_99", 8'h99, 99);
    check("up_99_tick", tick, 1'b1);
    check("up_99_nowrap", wrap, 1'b0);
    cyc(4);
    expect_bcd("up_00", 8'h00, 0);
    check("up_00_wrap", wrap, 1'b1);
    check("up_tick_count", cnt_tick - t0, 2);
    check("up_wrap_count", cnt_wrap - w0, 1);

    // Count down through 00->99 and a tens borrow.
    up = 1'b0;
    do_load(8'h01);
    expect_bcd("dn_load01", 8'h01, 1);
    cyc(4);
    expect_bcd("dn_00", 8'h00, 0);
    check("dn_00_nowrap", wrap, 1'b0);
    cyc(4);
    expect_bcd("dn_99", 8'h99, 99);
    check("dn_99_wrap", wrap, 1'b1);
    do_load(8'h90);
    cyc(4);
    expect_bcd("dn_borrow_89", 8'h89, 89);
    check("dn_89_tick", tick, 1'b1);

    // Clear, then illegal loads in IDLE.
    up = 1'b1; clear = 1'b1;
    cyc(1);
    clear = 1'b0; run = 1'b0;
    expect_bcd("clr_digits", 8'h00, 0);
    check("clr_state", state, 2'b00);
    do_load(8'h26);
    expect_bcd("ld_26", 8'h26, 26);
    e0 = cnt_err;
    do_load(8'h3A);
    check("ld_3A_err", load_err, 1'b1);
    expect_bcd("ld_3A_keep", 8'h26, 26);
    do_load(8'hA3);
    check("ld_A3_err", load_err, 1'b1);
    expect_bcd("ld_A3_keep", 8'h26, 26);
    do_load(8'h47);
    expect_bcd("ld_47", 8'h47, 47);
    check("ld_47_noerr", load_err, 1'b0);
    check("ld_err_count", cnt_err - e0, 2);

    // Hold with the prescaler at 2, then resume.
    run = 1'b1;
    cyc(1);
    check("hold_run_entered", state, 2'b01);
    cyc(2);
    run = 1'b0;
    cyc(1);
    check("hold_state", state, 2'b10);
    t0 = cnt_tick;
    cyc(10);
    check("hold_no_tick", cnt_tick - t0, 0);
    check("hold_state_kept", state, 2'b10);
    expect_bcd("hold_digits", 8'h47, 47);
    run = 1'b1;
    cyc(1);
    check("resume_state", state, 2'b01);
    check("resume_no_tick_yet", tick, 1'b0);
    cyc(1);
    check("resume_tick", tick, 1'b1);
    expect_bcd("resume_48", 8'h48, 48);

    // Load on a step edge wins over the step.
    cyc(3);
    do_load(8'h55);
    expect_bcd("coll_load55", 8'h55, 55);
    check("coll_no_tick", tick, 1'b0);
    cyc(4);
    expect_bcd("coll_next_56", 8'h56, 56);
    check("coll_next_tick", tick, 1'b1);

    // Clear and load on the same edge: clear wins, no error pulse.
    clear = 1'b1; load = 1'b1; load_val = 8'hAA;
    cyc(1);
    expect_bcd("clrld_bad_digits", 8'h00, 0);
    check("clrld_bad_state", state, 2'b00);
    check("clrld_bad_noerr", load_err, 1'b0);
    load_val = 8'h33;
    cyc(1);
    clear = 1'b0; load = 1'b0;
    expect_bcd("clrld_ok_digits", 8'h00, 0);
    check("clrld_ok_state", state, 2'b00);

    // Reset in the middle of counting, with a load pending.
    cyc(1);
    do_load(8'h64);
    cyc(2);
    Resetn = 1'b0; load = 1'b1; load_val = 8'h77;
    cyc(1);
    expect_bcd("midrst_digits", 8'h00, 0);
    check("midrst_state", state, 2'b00);
    check("midrst_pulses", {tick, wrap, load_err}, 3'b000);
    Resetn = 1'b1; load = 1'b0; run = 1'b0;
    cyc(2);
    check("midrst_idle", state, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
